dino_sprite_engine: RTL and testbench
=====================================

# dino_sprite_engine

Parametrised player-sprite engine for the VGA dinosaur game. Replaces the fixed 82×88 jump renderer. Adds configurable sprite geometry and jump arc, a run/jump/duck/halt state machine with a two-frame run animation, and an external synchronous sprite ROM holding several poses. It sits between the VGA scan counter and the pixel mux, and produces one registered 1-bit `px` per scanned pixel.

## Interface
Parameters:
- `SPR_W`, 82: sprite width in pixels.
- `SPR_H`, 88: sprite height in pixels.
- `X0`, 80: left column of the sprite.
- `GROUND_Y`, 402: first row below the sprite when on the ground. Must satisfy `GROUND_Y >= SPR_H + HMAX`.
- `JUMP_T`, 30: jump duration in frames, ≥2.
- `ANIM_DIV`, 6: frames per run-leg toggle, ≥1.
- `AW`, 15: ROM address width. Must satisfy `2^AW >= 4*SPR_W*SPR_H`.

Ports:
- `CLK`, in, 1: pixel clock.
- `RESET`, in, 1: reset, synchronous, active-low.
- `fresh`, in, 1: frame strobe level from the VGA timing block.
- `game_status`, in, 1: 1 = game running.
- `button_jump`, in, 1: jump request, level.
- `button_duck`, in, 1: duck request, level.
- `row_addr`, in, 9: current scan row.
- `col_addr`, in, 10: current scan column.
- `rom_addr`, out, AW: sprite ROM address.
- `rom_data`, in, 1: ROM pixel. Valid one clock after `rom_addr` updates.
- `px`, out, 1: sprite pixel.
- `jumping`, out, 1: state == JUMP.
- `height`, out, 10: current lift above ground, in rows.

## Operation
- **Frame tick.** `fresh` is sampled through two flops `f1`, `f2`. `tick = f2 & ~f1` (falling edge), which is a 1-clock pulse. All state, `t`, and animation updates happen only on `tick`.
- **States:** HALT, RUN, JUMP, DUCK. Reset enters HALT with `t=0`, `anim_cnt=0`, `leg=0`.
- **Any state:** on `tick` with `game_status=0`, go to HALT and hold `t`, `leg` and pose. The sprite freezes mid-air.
- **HALT:** on `tick` with `game_status=1`, go to RUN with `t=0`.
- **RUN:**
  - `tick` with `button_jump` → JUMP, `t<=1`. Jump has priority over duck.
  - Otherwise `tick` with `button_duck` → DUCK.
  - `anim_cnt` counts ticks. When it reaches `ANIM_DIV-1` it wraps to 0 and `leg` toggles.
- **JUMP:**
  - Each `tick`: `t<=t+1`.
  - `tick` with `t==JUMP_T` → `t<=0` and go to RUN.
  - Buttons are ignored in this state.
- **DUCK:**
  - `tick` with `button_duck=0` → RUN.
  - `button_jump` is ignored while ducking.
  - `anim_cnt`/`leg` keep toggling as in RUN.
- **Pose index:**
  - HALT/JUMP → 0.
  - RUN → 1 + `leg`.
  - DUCK → 3.
- **Height:** `height = (t*(JUMP_T - t)) >> 1`.
  - Unsigned; intermediate product is 2×ceil(log2(JUMP_T+1)) bits.
  - Registered one clock after `t` changes.
  - `HMAX = floor((JUMP_T/2)^2/2)`, which is 112 for `JUMP_T`=30.
- **Hit box:** `top = GROUND_Y - SPR_H - height`.
  - `in_box = (top <= row_addr < GROUND_Y - height) && (X0 <= col_addr < X0 + SPR_W)`.
  - Compare at 11 bits, unsigned.
- **ROM address:** `rom_addr = pose*SPR_W*SPR_H + (row_addr - top)*SPR_W + (col_addr - X0)`.
  - Column 0 is the leftmost pixel.
  - When not `in_box`, `rom_addr` holds its previous value.

## Timing
- **Reset values:** `px=0`, `rom_addr=0`, `jumping=0`, `height=0`, `f1=f2=0`. Reset overrides every other input.
- **Pixel pipeline:**
  - `row_addr`/`col_addr` sampled at edge k → `rom_addr` and `in_box_d1` updated at edge k.
  - ROM returns data after edge k+1; `in_box_d2` is also valid then.
  - At edge k+2: `px <= in_box_d2 & rom_data`.
  - Fixed latency of 2 clocks, with no bubbles.
- **Tick latency:** a `fresh` 1→0 transition seen at edge n gives `tick` high during the cycle after edge n+1. State, `t`, `jumping` and `leg` update at edge n+2. `height` updates at edge n+3.
- `height`, `top` and pose may change mid-frame only if `fresh` falls mid-frame. The VGA block guarantees `fresh` falls in vertical blanking.
- **Full arc:** a jump lasts exactly `JUMP_T` ticks from launch to the return to RUN. `jumping` is high for those `JUMP_T` frames.

## Test plan
- **Reset.** Hold `RESET=0` for 3 clocks with random inputs → `px=0`, `rom_addr=0`, `jumping=0`, `height=0`. After 2 ticks with `game_status=0` the engine is still in HALT.
- **Jump arc.** Defaults, `game_status=1`, `button_jump` pulsed over one tick → `height` per tick is 14, 28, 40, 52, 62, …, 112 at t=15, …, 14, 0. `jumping` drops on tick 30 after launch.
- **Pixel pipeline.** Sprite on ground, scan row 314 col 80 → `rom_addr = 1*7216 + 0 + 0` (RUN, `leg=0`) one edge later. `px` equals the ROM bit two edges after the scan. At col 162 and at row 402 → `px=0`.
- **Priority and duck.** `button_jump=1` and `button_duck=1` on the same tick in RUN → JUMP. Duck held through the jump → DUCK on landing tick +1. Jump pressed while ducking → no jump.
- **Freeze.** `game_status` dropped at t=10 → `height` held at 100 and state HALT. Restore → RUN with `t=0`, `height=0`.
- **Animation and tick detect.** `ANIM_DIV=2` → pose alternates 1,1,2,2 over consecutive ticks. A `fresh` held low for many clocks produces exactly one tick per falling edge.

Source files
------------

// File: rtl/dino_sprite_engine.sv
// dino_sprite_engine
// Player-sprite engine for the VGA dinosaur game. Tracks the dinosaur's
// run/jump/duck/halt state once per frame. It turns the current scan position
// into a sprite-ROM address and produces one registered sprite pixel per
// scanned pixel, with a fixed two-clock latency.
//
// Ports
//   CLK          pixel clock
//   RESET        synchronous reset, active low
//   fresh        frame strobe level; its falling edge is the frame tick
//   game_status  1 = game running, 0 = freeze in HALT
//   button_jump  jump request (level)
//   button_duck  duck request (level)
//   row_addr     current scan row
//   col_addr     current scan column
//   rom_addr     sprite ROM address (held while the scan is outside the sprite)
//   rom_data     ROM pixel, valid one clock after rom_addr
//   px           sprite pixel
//   jumping      high while in JUMP
//   height       current lift above ground, in rows
module dino_sprite_engine #(
  parameter int unsigned SPR_W    = 82,
  parameter int unsigned SPR_H    = 88,
  parameter int unsigned X0       = 80,
  parameter int unsigned GROUND_Y = 402,
  parameter int unsigned JUMP_T   = 30,
  parameter int unsigned ANIM_DIV = 6,
  parameter int unsigned AW       = 15
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          fresh,
  input  logic          game_status,
  input  logic          button_jump,
  input  logic          button_duck,
  input  logic [8:0]    row_addr,
  input  logic [9:0]    col_addr,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_data,
  output logic          px,
  output logic          jumping,
  output logic [9:0]    height
);

  localparam int unsigned TW     = $clog2(JUMP_T + 1);
  localparam int unsigned CW     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int unsigned PoseSz = SPR_W * SPR_H;

  localparam logic [TW-1:0] JumpEnd  = TW'(JUMP_T);
  localparam logic [CW-1:0] AnimLast = CW'(ANIM_DIV - 1);
  localparam logic [10:0]   BoxLeft  = 11'(X0);
  localparam logic [10:0]   BoxRight = 11'(X0 + SPR_W);
  localparam logic [10:0]   TopBase  = 11'(GROUND_Y - SPR_H);
  localparam logic [10:0]   BotBase  = 11'(GROUND_Y);

  typedef enum logic [1:0] {StHalt, StRun, StJump, StDuck} state_e;

  // Run poses live at ROM slots 1 and 2, selected by the current leg.
  function automatic logic [1:0] run_pose(input logic l);
    return l ? 2'd2 : 2'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Frame tick: falling edge of fresh, registered once more so the tick sits
  // one clock after the edge is detected.
  // ---------------------------------------------------------------------------
  logic f1_q, f2_q, tick_q;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      f1_q   <= 1'b0;
      f2_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      f1_q   <= fresh;
      f2_q   <= f1_q;
      tick_q <= f2_q & ~f1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Motion state machine, stepped only on tick.
  // ---------------------------------------------------------------------------
  state_e          state_q;
  logic [TW-1:0]   t_q;
  logic [CW-1:0]   anim_cnt_q;
  logic            leg_q;
  logic [1:0]      pose_q;
  logic            jumping_q;

  logic            anim_wrap;
  logic [CW-1:0]   anim_cnt_nxt;
  logic            leg_nxt;

  assign anim_wrap    = (anim_cnt_q == AnimLast);
  assign anim_cnt_nxt = anim_wrap ? '0 : anim_cnt_q + CW'(1);
  assign leg_nxt      = leg_q ^ anim_wrap;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= StHalt;
      t_q        <= '0;
      anim_cnt_q <= '0;
      leg_q      <= 1'b0;
      pose_q     <= 2'd0;
      jumping_q  <= 1'b0;
    end else if (tick_q) begin
      if (!game_status) begin
        // Freeze: t, leg, animation count and pose all hold, so the sprite
        // stays wherever it was, mid-air included.
        state_q   <= StHalt;
        jumping_q <= 1'b0;
      end else begin
        unique case (state_q)
          StHalt: begin
            state_q <= StRun;
            t_q     <= '0;
            pose_q  <= run_pose(leg_q);
          end
          StRun: begin
            anim_cnt_q <= anim_cnt_nxt;
            leg_q      <= leg_nxt;
            if (button_jump) begin
              state_q   <= StJump;
              t_q       <= TW'(1);
              pose_q    <= 2'd0;
              jumping_q <= 1'b1;
            end else if (button_duck) begin
              state_q <= StDuck;
              pose_q  <= 2'd3;
            end else begin
              pose_q <= run_pose(leg_nxt);
            end
          end
          StJump: begin
            if (t_q == JumpEnd) begin
              state_q   <= StRun;
              t_q       <= '0;
              jumping_q <= 1'b0;
              pose_q    <= run_pose(leg_q);
            end else begin
              t_q <= t_q + TW'(1);
            end
          end
          StDuck: begin
            anim_cnt_q <= anim_cnt_nxt;
            leg_q      <= leg_nxt;
            if (!button_duck) begin
              state_q <= StRun;
              pose_q  <= run_pose(leg_nxt);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Jump height: parabola t*(JUMP_T-t)/2, registered one clock behind t.
  // ---------------------------------------------------------------------------
  logic [2*TW-1:0] t_ext, rem_ext, prod;
  logic [9:0]      height_q;

  assign t_ext   = {{TW{1'b0}}, t_q};
  assign rem_ext = {{TW{1'b0}}, JumpEnd - t_q};
  assign prod    = t_ext * rem_ext;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      height_q <= '0;
    end else begin
      height_q <= 10'(prod >> 1);
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel pipeline: scan -> rom_addr/in_box_d1 -> rom_data/in_box_d2 -> px.
  // ---------------------------------------------------------------------------
  logic [10:0]   row_w, col_w, top_w, bot_w;
  logic          in_box;
  logic [AW-1:0] addr_w;
  logic [AW-1:0] rom_addr_q;
  logic          in_box_d1_q, in_box_d2_q, px_q;

  assign row_w = {2'b00, row_addr};
  assign col_w = {1'b0, col_addr};
  assign top_w = TopBase - {1'b0, height_q};
  assign bot_w = BotBase - {1'b0, height_q};

  assign in_box = (row_w >= top_w) && (row_w < bot_w) &&
                  (col_w >= BoxLeft) && (col_w < BoxRight);

  assign addr_w = AW'(pose_q) * AW'(PoseSz) +
                  AW'(row_w - top_w) * AW'(SPR_W) +
                  AW'(col_w - BoxLeft);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rom_addr_q  <= '0;
      in_box_d1_q <= 1'b0;
      in_box_d2_q <= 1'b0;
      px_q        <= 1'b0;
    end else begin
      // Outside the box the address is held so the ROM sees no needless toggling.
      if (in_box) begin
        rom_addr_q <= addr_w;
      end
      in_box_d1_q <= in_box;
      in_box_d2_q <= in_box_d1_q;
      px_q        <= in_box_d2_q & rom_data;
    end
  end

  assign rom_addr = rom_addr_q;
  assign px       = px_q;
  assign jumping  = jumping_q;
  assign height   = height_q;

endmodule

// File: tb/tb_dino_sprite_engine.sv
module tb_dino_sprite_engine;

  localparam int SPR_W = 82;
  localparam int SPR_H = 88;
  localparam int X0    = 80;
  localparam int GY    = 402;
  localparam int JT    = 30;
  localparam int AD    = 2;
  localparam int AW    = 15;
  localparam int PSZ   = SPR_W * SPR_H;

  localparam int HALT = 0;
  localparam int RUN  = 1;
  localparam int JUMP = 2;
  localparam int DUCK = 3;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          fresh;
  logic          game_status;
  logic          button_jump;
  logic          button_duck;
  logic [8:0]    row_addr;
  logic [9:0]    col_addr;
  logic [AW-1:0] rom_addr;
  logic          rom_data = 1'b0;
  logic          px;
  logic          jumping;
  logic [9:0]    height;

  always #5 CLK = ~CLK;

  dino_sprite_engine #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .X0(X0), .GROUND_Y(GY),
    .JUMP_T(JT), .ANIM_DIV(AD), .AW(AW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .fresh(fresh), .game_status(game_status),
    .button_jump(button_jump), .button_duck(button_duck),
    .row_addr(row_addr), .col_addr(col_addr), .rom_addr(rom_addr),
    .rom_data(rom_data), .px(px), .jumping(jumping), .height(height)
  );

  // Pseudo-random sprite ROM contents.
  function automatic bit rom_bit(input int a);
    int unsigned x;
    x = a * 32'h2545F491;
    x = x ^ (x >> 13);
    return x[7];
  endfunction

  always @(posedge CLK) rom_data <= rom_bit(int'(rom_addr));

  function automatic int height_of(input int t);
    return (t * (JT - t)) / 2;
  endfunction

  int vectors = 0;
  int miscompares = 0;
  bit rand_scan = 1'b1;

  // Behavioural model state
  int m_mode, m_t, m_cnt, m_leg, m_pose, m_h, m_rom_addr, m_px;
  bit hist[3];   // sampled fresh, edges e-1, e-2, e-3
  bit pib[2];    // in-box flag of the scans one and two edges ago
  int pad[2];    // rom address after those edges

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic anim_step();
    m_cnt++;
    if (m_cnt == AD) begin
      m_cnt = 0;
      m_leg = 1 - m_leg;
    end
  endtask

  task automatic apply_tick();
    if (!game_status) begin
      m_mode = HALT;
    end else if (m_mode == HALT) begin
      m_mode = RUN;
      m_t    = 0;
      m_pose = 1 + m_leg;
    end else if (m_mode == RUN) begin
      anim_step();
      if (button_jump) begin
        m_mode = JUMP; m_t = 1; m_pose = 0;
      end else if (button_duck) begin
        m_mode = DUCK; m_pose = 3;
      end else begin
        m_pose = 1 + m_leg;
      end
    end else if (m_mode == JUMP) begin
      if (m_t == JT) begin
        m_mode = RUN; m_t = 0; m_pose = 1 + m_leg;
      end else begin
        m_t++;
      end
    end else begin
      anim_step();
      if (!button_duck) begin
        m_mode = RUN; m_pose = 1 + m_leg;
      end
    end
  endtask

  task automatic model_step();
    int r, c, top, bot, addr, new_h;
    bit inb, tick;
    if (!RESET) begin
      m_mode = HALT; m_t = 0; m_cnt = 0; m_leg = 0; m_pose = 0; m_h = 0;
      m_rom_addr = 0; m_px = 0;
      hist[0] = 0; hist[1] = 0; hist[2] = 0;
      pib[0] = 0; pib[1] = 0; pad[0] = 0; pad[1] = 0;
      return;
    end
    r    = int'(row_addr);
    c    = int'(col_addr);
    top  = GY - SPR_H - m_h;
    bot  = GY - m_h;
    inb  = (r >= top) && (r < bot) && (c >= X0) && (c < X0 + SPR_W);
    addr = m_pose * PSZ + (r - top) * SPR_W + (c - X0);
    m_px = pib[1] && rom_bit(pad[1]);
    pib[1] = pib[0];
    pad[1] = pad[0];
    if (inb) m_rom_addr = addr;
    pib[0] = inb;
    pad[0] = m_rom_addr;
    new_h = height_of(m_t);
    tick  = !hist[1] && hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = fresh;
    if (tick) apply_tick();
    m_h = new_h;
  endtask

  task automatic cycle();
    if (rand_scan) begin
      if ($urandom_range(0, 7) == 0) begin
        row_addr = 9'($urandom);
        col_addr = 10'($urandom);
      end else begin
        row_addr = 9'($urandom_range(200, 420));
        col_addr = 10'($urandom_range(60, 180));
      end
    end
    @(posedge CLK);
    model_step();
    #1;
    chk("px", int'(px), m_px);
    chk("rom_addr", int'(rom_addr), m_rom_addr);
    chk("jumping", int'(jumping), int'(m_mode == JUMP));
    chk("height", int'(height), m_h);
  endtask

  task automatic frame(input int hi, input int lo, input bit jitter);
    fresh = 1'b1;
    for (int i = 0; i < hi + lo; i++) begin
      if (i == hi) fresh = 1'b0;
      if (jitter && $urandom_range(0, 15) == 0) button_jump = ~button_jump;
      if (jitter && $urandom_range(0, 15) == 0) button_duck = ~button_duck;
      cycle();
    end
  endtask

  task automatic probe(input int r, input int c, input int exp_addr, input string name);
    rand_scan = 1'b0;
    row_addr  = 9'(r);
    col_addr  = 10'(c);
    cycle();
    chk(name, int'(rom_addr), exp_addr);
    rand_scan = 1'b1;
  endtask

  int exp_h[4] = '{28, 40, 52, 62};
  int exp_pose[4] = '{1, 2, 2, 1};

  initial begin
    RESET = 1'b0; fresh = 1'b0; game_status = 1'b0;
    button_jump = 1'b0; button_duck = 1'b0;
    row_addr = '0; col_addr = '0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      fresh = 1'($urandom); game_status = 1'($urandom);
      button_jump = 1'($urandom); button_duck = 1'($urandom);
      cycle();
    end
    chk("rst_px", int'(px), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_jumping", int'(jumping), 0);
    chk("rst_height", int'(height), 0);
    RESET = 1'b1; fresh = 1'b0; game_status = 1'b0;
    button_jump = 1'b0; button_duck = 1'b0;

    // Two ticks halted: still pose 0 on the ground
    frame(4, 6, 0);
    frame(4, 6, 0);
    probe(314, 81, 1, "halt_pose");
    chk("halt_jumping", int'(jumping), 0);

    // Start running, pixel pipeline on the sprite corners
    game_status = 1'b1;
    frame(4, 6, 0);
    probe(314, 80, 7216, "run_rom_addr");
    rand_scan = 1'b0;
    cycle(); cycle();
    chk("run_px", int'(px), int'(rom_bit(7216)));
    col_addr = 10'd162;
    cycle();
    chk("hold_rom_addr", int'(rom_addr), 7216);
    cycle(); cycle();
    chk("px_col162", int'(px), 0);
    row_addr = 9'd402; col_addr = 10'd80;
    cycle(); cycle(); cycle();
    chk("px_row402", int'(px), 0);
    row_addr = 9'd401; col_addr = 10'd161;
    cycle();
    chk("corner_rom_addr", int'(rom_addr), 14431);
    cycle(); cycle();
    chk("corner_px", int'(px), int'(rom_bit(14431)));
    rand_scan = 1'b1;

    // Two-frame run animation with ANIM_DIV=2
    for (int k = 0; k < 4; k++) begin
      frame(4, 6, 0);
      probe(314, 80, exp_pose[k] * PSZ, "anim_pose");
    end

    // Jump and duck together: jump wins; duck held through the arc
    button_jump = 1'b1; button_duck = 1'b1;
    frame(4, 6, 0);
    chk("prio_jumping", int'(jumping), 1);
    chk("arc_h1", int'(height), 14);
    button_jump = 1'b0;
    for (int k = 2; k <= JT + 1; k++) begin
      frame(4, 6, 0);
      if (k <= 5) chk("arc_h", int'(height), exp_h[k-2]);
      if (k == 15) chk("arc_peak", int'(height), 112);
      if (k == JT) begin
        chk("arc_last_h", int'(height), 0);
        chk("arc_last_jumping", int'(jumping), 1);
      end
      if (k == JT + 1) chk("landing_jumping", int'(jumping), 0);
    end
    frame(4, 6, 0);
    probe(314, 80, 3 * PSZ, "duck_pose");
    button_jump = 1'b1;
    frame(4, 6, 0);
    chk("duck_no_jump", int'(jumping), 0);
    probe(314, 80, 3 * PSZ, "duck_pose_held");

    // Freeze mid-air at t=10
    button_jump = 1'b0; button_duck = 1'b0;
    frame(4, 6, 0);
    button_jump = 1'b1;
    frame(4, 6, 0);
    button_jump = 1'b0;
    for (int k = 0; k < 9; k++) frame(4, 6, 0);
    chk("t10_height", int'(height), 100);
    game_status = 1'b0;
    frame(4, 6, 0);
    chk("freeze_height", int'(height), 100);
    chk("freeze_jumping", int'(jumping), 0);
    frame(4, 6, 0);
    chk("freeze_height2", int'(height), 100);
    probe(214, 80, 0, "freeze_pose");
    game_status = 1'b1;
    frame(4, 6, 0);
    chk("restore_height", int'(height), 0);
    chk("restore_jumping", int'(jumping), 0);

    // A long low fresh gives exactly one tick
    button_jump = 1'b1;
    frame(4, 40, 0);
    button_jump = 1'b0;
    chk("long_low_height", int'(height), 14);
    frame(4, 6, 0);
    chk("next_tick_height", int'(height), 28);

    // Randomized frames, buttons and occasional resets
    for (int f = 0; f < 250; f++) begin
      game_status = ($urandom_range(0, 9) != 0);
      button_jump = ($urandom_range(0, 3) == 0);
      button_duck = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 59) == 0) begin
        RESET = 1'b0;
        cycle(); cycle();
        RESET = 1'b1;
      end
      frame($urandom_range(1, 10), $urandom_range(2, 12), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
